// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one unified memory port between instruction fetch (IF) and the
// MEM stage. A two-process FSM arbitrates the requesters. It drives a
// registered request/acknowledge bus toward memory. Store width codes are
// turned into byte masks with lane-replicated write data. Each completion
// returns a one-cycle valid pulse.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset (0 = reset)
//   if_req/if_addr    fetch request (level) and address
//   if_rdata/if_valid fetched word and one-cycle completion pulse
//   mem_req/mem_we    data request (level) and store select
//   mem_addr          data address
//   mem_wdata         right-aligned store data
//   mem_swhb          store width: 01 word, 10 half, 11 byte, 00 word
//   mem_rdata         raw 32-bit load word
//   mem_valid         one-cycle completion pulse for the data access
//   mem_err           misaligned-store flag, coincident with mem_valid
//   bus_*             registered memory request bus
//   bus_ack/bus_rdata memory completion and read data
//   stall_if          combinational freeze for IF
//   stall_mem         combinational freeze for MEM
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [1:0]            mem_swhb,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_valid,
  output logic                  mem_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_wmask,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  stall_if,
  output logic                  stall_mem
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  state_t                  state_reg, state_next;
  logic                    last_grant_reg;
  logic                    bus_req_reg;
  logic                    bus_we_reg;
  logic [ADDR_WIDTH-1:0]   bus_addr_reg;
  logic [DATA_WIDTH-1:0]   bus_wdata_reg;
  logic [3:0]              bus_wmask_reg;
  logic [DATA_WIDTH-1:0]   if_rdata_reg;
  logic [DATA_WIDTH-1:0]   mem_rdata_reg;
  logic                    if_valid_reg;
  logic                    mem_valid_reg;
  logic                    mem_err_reg;

  logic                    grant_if;
  logic                    grant_mem;
  logic                    mem_misaligned;
  logic [3:0]              mem_mask;
  logic [DATA_WIDTH-1:0]   mem_wdata_lane;
  logic [1:0]              lane;

  // The bus always carries word-aligned addresses, so the fetch address
  // low bits are never needed.
  logic unused_if_addr_lsb;
  assign unused_if_addr_lsb = ^if_addr[1:0];

  assign lane = mem_addr[1:0];

  // Store width decode. Loads read the full word. Misalignment applies
  // only to stores.
  always_comb begin
    mem_mask       = 4'b1111;
    mem_wdata_lane = mem_wdata;
    mem_misaligned = 1'b0;
    if (mem_we) begin
      case (mem_swhb)
        2'b11: begin
          mem_mask       = 4'b0001 << lane;
          mem_wdata_lane = {4{mem_wdata[7:0]}};
        end
        2'b10: begin
          mem_mask       = 4'b0011 << {lane[1], 1'b0};
          mem_wdata_lane = {2{mem_wdata[15:0]}};
          mem_misaligned = lane[0];
        end
        default: begin
          mem_misaligned = (lane != 2'b00);
        end
      endcase
    end
  end

  // Next-state and grant decisions. On a tie the requester that did not
  // win last time is served. last_grant resets to IF, so MEM wins the first
  // tie.
  always_comb begin
    state_next = state_reg;
    grant_if   = 1'b0;
    grant_mem  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_req && (!if_req || last_grant_reg == GRANT_IF)) begin
          grant_mem  = 1'b1;
          state_next = mem_misaligned ? DONE : BUSY_MEM;
        end else if (if_req) begin
          grant_if   = 1'b1;
          state_next = BUSY_IF;
        end
      end
      BUSY_IF:  if (bus_ack) state_next = DONE;
      BUSY_MEM: if (bus_ack) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= GRANT_IF;
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= '0;
      bus_wdata_reg  <= '0;
      bus_wmask_reg  <= 4'b0000;
      if_rdata_reg   <= '0;
      mem_rdata_reg  <= '0;
      if_valid_reg   <= 1'b0;
      mem_valid_reg  <= 1'b0;
      mem_err_reg    <= 1'b0;
    end else begin
      // The valid and error flags are set only on the transition into
      // DONE. That makes each one a single-cycle pulse.
      if_valid_reg  <= (state_reg == BUSY_IF) && bus_ack;
      mem_valid_reg <= ((state_reg == BUSY_MEM) && bus_ack)
                       || (grant_mem && mem_misaligned);
      mem_err_reg   <= grant_mem && mem_misaligned;

      if (grant_if) begin
        last_grant_reg <= GRANT_IF;
        bus_req_reg    <= 1'b1;
        bus_we_reg     <= 1'b0;
        bus_addr_reg   <= {if_addr[ADDR_WIDTH-1:2], 2'b00};
        bus_wdata_reg  <= '0;
        bus_wmask_reg  <= 4'b0000;
      end

      // A misaligned store still counts as MEM's turn. This keeps the
      // alternation fair, but the bus stays idle.
      if (grant_mem) begin
        last_grant_reg <= GRANT_MEM;
        if (!mem_misaligned) begin
          bus_req_reg   <= 1'b1;
          bus_we_reg    <= mem_we;
          bus_addr_reg  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          bus_wdata_reg <= mem_wdata_lane;
          bus_wmask_reg <= mem_mask;
        end
      end

      // bus_ack is honoured only in the BUSY states, where bus_req is high.
      if ((state_reg == BUSY_IF) && bus_ack) begin
        if_rdata_reg <= bus_rdata;
        bus_req_reg  <= 1'b0;
      end
      if ((state_reg == BUSY_MEM) && bus_ack) begin
        mem_rdata_reg <= bus_rdata;
        bus_req_reg   <= 1'b0;
      end
    end
  end

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_wmask = bus_wmask_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_rdata = mem_rdata_reg;
  assign if_valid  = if_valid_reg;
  assign mem_valid = mem_valid_reg;
  assign mem_err   = mem_err_reg;

  assign stall_if  = if_req  & ~if_valid_reg;
  assign stall_mem = mem_req & ~mem_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_swhb;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall_if;
  logic        stall_mem;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_swhb  (mem_swhb),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_err   (mem_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wmask (bus_wmask),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] grant_addr [4];
  logic        grant_mem  [4];

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_swhb = 2'b01; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) tick;
    check("rst_bus_req",   {31'd0, bus_req},   32'd0);
    check("rst_bus_we",    {31'd0, bus_we},    32'd0);
    check("rst_bus_addr",  bus_addr,           32'd0);
    check("rst_bus_wdata", bus_wdata,          32'd0);
    check("rst_bus_wmask", {28'd0, bus_wmask}, 32'd0);
    check("rst_if_rdata",  if_rdata,           32'd0);
    check("rst_mem_rdata", mem_rdata,          32'd0);
    check("rst_if_valid",  {31'd0, if_valid},  32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_err",   {31'd0, mem_err},   32'd0);
    reset = 1'b1;
    tick;

    // Fetch only, zero-wait memory
    if_req = 1'b1; if_addr = 32'h0000_0040; bus_rdata = 32'h0000_0013;
    #1;
    check("f_c0_stall_if", {31'd0, stall_if}, 32'd1);
    check("f_c0_bus_req",  {31'd0, bus_req},  32'd0);
    tick;
    check("f_c1_bus_req",  {31'd0, bus_req},   32'd1);
    check("f_c1_bus_addr", bus_addr,           32'h40);
    check("f_c1_wmask",    {28'd0, bus_wmask}, 32'd0);
    check("f_c1_we",       {31'd0, bus_we},    32'd0);
    check("f_c1_stall_if", {31'd0, stall_if},  32'd1);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    check("f_c2_if_valid", {31'd0, if_valid}, 32'd1);
    check("f_c2_if_rdata", if_rdata,          32'h13);
    check("f_c2_stall_if", {31'd0, stall_if}, 32'd0);
    check("f_c2_bus_req",  {31'd0, bus_req},  32'd0);
    if_req = 1'b0;
    tick;
    check("f_c3_if_valid", {31'd0, if_valid}, 32'd0);

    // Simultaneous requests right after reset: MEM, IF, MEM, IF
    reset = 1'b0; tick; reset = 1'b1; tick;
    if_req = 1'b1; if_addr = 32'h80;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    grant_addr[0] = 32'h100; grant_mem[0] = 1'b1;
    grant_addr[1] = 32'h80;  grant_mem[1] = 1'b0;
    grant_addr[2] = 32'h100; grant_mem[2] = 1'b1;
    grant_addr[3] = 32'h80;  grant_mem[3] = 1'b0;
    #1;
    check("arb_stall_if",  {31'd0, stall_if},  32'd1);
    check("arb_stall_mem", {31'd0, stall_mem}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick;
      check($sformatf("arb%0d_bus_req", k),  {31'd0, bus_req}, 32'd1);
      check($sformatf("arb%0d_bus_addr", k), bus_addr, grant_addr[k]);
      check($sformatf("arb%0d_wmask", k), {28'd0, bus_wmask},
            grant_mem[k] ? 32'hF : 32'h0);
      bus_ack = 1'b1; bus_rdata = 32'hA000_0000 + k;
      tick;
      bus_ack = 1'b0;
      check($sformatf("arb%0d_if_valid", k),  {31'd0, if_valid},  {31'd0, !grant_mem[k]});
      check($sformatf("arb%0d_mem_valid", k), {31'd0, mem_valid}, {31'd0, grant_mem[k]});
      if (grant_mem[k])
        check($sformatf("arb%0d_mem_rdata", k), mem_rdata, 32'hA000_0000 + k);
      else
        check($sformatf("arb%0d_if_rdata", k), if_rdata, 32'hA000_0000 + k);
      tick;
      check($sformatf("arb%0d_done_clr", k), {30'd0, if_valid, mem_valid}, 32'd0);
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick;

    // Store byte at 0x203
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h203; mem_wdata = 32'h0000_00AB;
    mem_swhb = 2'b11; bus_rdata = 32'h1111_1111;
    tick;
    check("sb_wmask", {28'd0, bus_wmask}, 32'h8);
    check("sb_wdata", bus_wdata,          32'hABAB_ABAB);
    check("sb_addr",  bus_addr,           32'h200);
    check("sb_we",    {31'd0, bus_we},    32'd1);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    check("sb_mem_valid", {31'd0, mem_valid}, 32'd1);
    check("sb_mem_err",   {31'd0, mem_err},   32'd0);
    check("sb_mem_rdata", mem_rdata,          32'h1111_1111);
    mem_req = 1'b0;
    tick;

    // Store half at 0x202
    mem_req = 1'b1; mem_addr = 32'h202; mem_wdata = 32'hFFFF_1234; mem_swhb = 2'b10;
    tick;
    check("sh_wmask", {28'd0, bus_wmask}, 32'hC);
    check("sh_wdata", bus_wdata,          32'h1234_1234);
    check("sh_addr",  bus_addr,           32'h200);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    check("sh_mem_valid", {31'd0, mem_valid}, 32'd1);
    mem_req = 1'b0;
    tick;

    // Misaligned store word at 0x201
    mem_req = 1'b1; mem_addr = 32'h201; mem_wdata = 32'hCAFE_F00D; mem_swhb = 2'b01;
    bus_rdata = 32'h9999_9999;
    tick;
    check("mis_bus_req",   {31'd0, bus_req},   32'd0);
    check("mis_mem_valid", {31'd0, mem_valid}, 32'd1);
    check("mis_mem_err",   {31'd0, mem_err},   32'd1);
    check("mis_mem_rdata", mem_rdata,          32'h1111_1111);
    mem_req = 1'b0;
    tick;
    check("mis_after_valid", {31'd0, mem_valid}, 32'd0);
    check("mis_after_err",   {31'd0, mem_err},   32'd0);
    check("mis_after_req",   {31'd0, bus_req},   32'd0);

    // Three wait states on a half store at 0x302
    mem_req = 1'b1; mem_addr = 32'h302; mem_wdata = 32'h0000_5678; mem_swhb = 2'b10;
    bus_rdata = 32'h0BAD_0BAD;
    for (int c = 1; c <= 4; c++) begin
      tick;
      check($sformatf("ws_c%0d_req", c),   {31'd0, bus_req},   32'd1);
      check($sformatf("ws_c%0d_addr", c),  bus_addr,           32'h300);
      check($sformatf("ws_c%0d_mask", c),  {28'd0, bus_wmask}, 32'hC);
      check($sformatf("ws_c%0d_wdata", c), bus_wdata,          32'h5678_5678);
      check($sformatf("ws_c%0d_valid", c), {31'd0, mem_valid}, 32'd0);
      if (c == 4) bus_ack = 1'b1;
    end
    tick;
    bus_ack = 1'b0;
    check("ws_c5_valid", {31'd0, mem_valid}, 32'd1);
    mem_req = 1'b0;
    tick;

    // Stray ack while idle
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    tick;
    bus_ack = 1'b0;
    check("idle_ack_valids", {30'd0, if_valid, mem_valid}, 32'd0);
    check("idle_ack_req",    {31'd0, bus_req},             32'd0);
    check("idle_ack_rdata",  mem_rdata,                    32'h0BAD_0BAD);

    // Reset asserted during BUSY_MEM, then a late ack
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
    tick;
    check("rb_bus_req_busy", {31'd0, bus_req}, 32'd1);
    #2;
    reset = 1'b0; mem_req = 1'b0;
    #1;
    check("rb_bus_req",   {31'd0, bus_req},   32'd0);
    check("rb_bus_addr",  bus_addr,           32'd0);
    check("rb_bus_wmask", {28'd0, bus_wmask}, 32'd0);
    check("rb_bus_wdata", bus_wdata,          32'd0);
    check("rb_mem_rdata", mem_rdata,          32'd0);
    tick;
    reset = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    tick;
    bus_ack = 1'b0;
    check("late_ack_valid", {31'd0, mem_valid}, 32'd0);
    check("late_ack_rdata", mem_rdata,          32'd0);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
